// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the binary-to-BCD serial controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPT,
    HOLD
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Decimal digits needed to represent 2^width - 1.
  function automatic int unsigned digits_for_width(input int unsigned width);
    longint unsigned max_val;
    int unsigned     d;
    max_val = (64'd1 << width) - 64'd1;
    d       = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Flags any packed BCD digit holding a value above 9.
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          any_gt9
);

  always_comb begin
    any_gt9 = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) any_gt9 = 1'b1;
    end
  end

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Serializes a binary word into an external BCD digit-cell chain and
// captures the packed digits (plus an overflow flag) behind a valid/ready pair.
module bin2bcd_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = $clog2(WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          ser_out,
  output logic                          init_out,
  input  logic                          carry_top,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf,
  output logic                          out_valid,
  input  logic                          out_ready
);

  // Too few digits for the full input range: results above 10^DIGITS-1 raise ovf.
  if (DIGITS < digits_for_width(WIDTH)) begin : g_capacity_short
  end

  state_t                          state, state_nxt;
  logic [WIDTH-1:0]                sh, sh_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic                            ovf_acc, ovf_acc_nxt;
  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_nxt;
  logic                            ovf_nxt;
  logic                            valid_nxt;
  logic                            digit_err;

  bcd_digit_check #(
    .DIGITS(DIGITS)
  ) u_digit_check (
    .bcd    (bcd_in),
    .any_gt9(digit_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      ovf_acc   <= ovf_acc_nxt;
      bcd_out   <= bcd_nxt;
      ovf       <= ovf_nxt;
      out_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    cnt_nxt     = cnt;
    ovf_acc_nxt = ovf_acc;
    bcd_nxt     = bcd_out;
    ovf_nxt     = ovf;
    valid_nxt   = out_valid;
    in_ready    = 1'b0;
    ser_out     = 1'b0;
    init_out    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_nxt      = bin_in;
          cnt_nxt     = '0;
          ovf_acc_nxt = 1'b0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        ser_out     = sh[WIDTH-1];
        init_out    = (cnt == '0);
        sh_nxt      = {sh[WIDTH-2:0], 1'b0};
        cnt_nxt     = cnt + CNT_W'(1);
        ovf_acc_nxt = ovf_acc | carry_top;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = CAPT;
      end
      // The chain keeps shifting afterwards, so its digits are only valid here.
      CAPT: begin
        bcd_nxt   = bcd_in;
        ovf_nxt   = ovf_acc | digit_err;
        valid_nxt = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Randomized bench: two controllers (3-digit and 2-digit chains) driven in lockstep.
module tb_bin2bcd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  bin_in;

  logic        in_ready3, ser3, init3, carry3, ovf3, valid3;
  logic [11:0] bcd_in3, bcd_out3;
  logic        in_ready2, ser2, init2, carry2, ovf2, valid2;
  logic [7:0]  bcd_in2, bcd_out2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_ctrl #(.WIDTH(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .bin_in(bin_in), .ser_out(ser3), .init_out(init3), .carry_top(carry3),
    .bcd_in(bcd_in3), .bcd_out(bcd_out3), .ovf(ovf3), .out_valid(valid3),
    .out_ready(out_ready)
  );

  bin2bcd_ctrl #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .bin_in(bin_in), .ser_out(ser2), .init_out(init2), .carry_top(carry2),
    .bcd_in(bcd_in2), .bcd_out(bcd_out2), .ovf(ovf2), .out_valid(valid2),
    .out_ready(out_ready)
  );

  // Behavioural digit cells: add-3-then-shift, carry masked during init.
  function automatic logic [3:0] cell_next(input logic [3:0] d, input logic b, input logic init);
    logic [3:0] a;
    if (init) return {3'b000, b};
    a = (d >= 4'd5) ? d + 4'd3 : d;
    return {a[2:0], b};
  endfunction

  function automatic logic cell_cout(input logic [3:0] d, input logic init);
    return !init && (d >= 4'd5);
  endfunction

  logic [3:0] dig3 [3] = '{default: '0};
  logic [3:0] dig2 [2] = '{default: '0};

  always @(posedge clk) begin
    dig3[0] <= cell_next(dig3[0], ser3, init3);
    dig3[1] <= cell_next(dig3[1], cell_cout(dig3[0], init3), init3);
    dig3[2] <= cell_next(dig3[2], cell_cout(dig3[1], init3), init3);
    dig2[0] <= cell_next(dig2[0], ser2, init2);
    dig2[1] <= cell_next(dig2[1], cell_cout(dig2[0], init2), init2);
  end

  assign bcd_in3 = {dig3[2], dig3[1], dig3[0]};
  assign bcd_in2 = {dig2[1], dig2[0]};
  assign carry3  = cell_cout(dig3[2], init3);
  assign carry2  = cell_cout(dig2[1], init2);

  // Expected result: decimal digits of v modulo 10^d, packed 4 bits each.
  function automatic logic [31:0] exp_bcd(input int unsigned v, input int unsigned d);
    logic [31:0] r = '0;
    for (int unsigned i = 0; i < d; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends at a negedge with the controllers in IDLE.
  task automatic convert(input logic [7:0] w, input int unsigned hold);
    logic [11:0] held;
    check("in_ready_idle", in_ready3, 1'b1);
    in_valid = 1'b1;
    bin_in   = w;
    @(negedge clk);
    in_valid = 1'b0;
    for (int unsigned j = 0; j < 9; j++) begin
      check("ser_out", ser3, (j < 8) ? 32'(w[7 - j]) : 32'd0);
      check("init_out", init3, (j == 0) ? 32'd1 : 32'd0);
      check("in_ready_busy", in_ready3, 1'b0);
      check("out_valid_early", valid3, 1'b0);
      in_valid  = 1'($urandom);
      bin_in    = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid3", valid3, 1'b1);
    check("bcd_out3", bcd_out3, exp_bcd(w, 3));
    check("ovf3", ovf3, 1'b0);
    check("out_valid2", valid2, 1'b1);
    check("bcd_out2", bcd_out2, exp_bcd(w, 2));
    check("ovf2", ovf2, (w >= 8'd100) ? 32'd1 : 32'd0);
    held = bcd_out3;
    for (int unsigned h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      bin_in   = 8'($urandom);
      @(negedge clk);
      check("hold_valid", valid3, 1'b1);
      check("hold_bcd", bcd_out3, held);
      check("hold_in_ready", in_ready3, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", valid3, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid3, 1'b0);
    check("rst_bcd", bcd_out3, 12'h000);
    check("rst_ovf", ovf3, 1'b0);
    check("rst_ser", ser3, 1'b0);
    check("rst_init", init3, 1'b0);
    check("rst_in_ready", in_ready3, 1'b1);
    reset = 1'b1;

    convert(8'd255, 0);
    convert(8'd0, 0);
    convert(8'd99, 0);
    convert(8'd128, 5);
    convert(8'd100, 1);

    // Abort a conversion with reset at cnt==3.
    in_valid = 1'b1;
    bin_in   = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_in_ready", in_ready3, 1'b1);
    check("abort_valid", valid3, 1'b0);
    check("abort_bcd", bcd_out3, 12'h000);
    check("abort_init", init3, 1'b0);
    convert(8'd42, 0);

    for (int unsigned v = 0; v < 256; v++) convert(8'(v), $urandom_range(0, 2));
    for (int unsigned k = 0; k < 40; k++) convert(8'($urandom), $urandom_range(0, 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
